// File: rtl/xadc_scan_pwm_if.sv
// xadc_scan_pwm_if: DRP handshake between the channel scanner (master) and the XADC (slave).
interface xadc_scan_pwm_if;
    logic        eoc_in;
    logic        drdy_in;
    logic [15:0] do_in;
    logic        den_out;
    logic        dwe_out;
    logic [6:0]  daddr_out;

    modport master (
        input  eoc_in,
        input  drdy_in,
        input  do_in,
        output den_out,
        output dwe_out,
        output daddr_out
    );

    modport slave (
        output eoc_in,
        output drdy_in,
        output do_in,
        input  den_out,
        input  dwe_out,
        input  daddr_out
    );
endinterface

// File: rtl/xadc_scan_pwm.sv
// xadc_scan_pwm: round-robin XADC DRP channel scanner feeding per-channel PWM brightness.
// Each end-of-conversion launches one DRP read of the current channel; the top DATA_W bits
// of the result become that channel's PWM duty at the next PWM period boundary.
// Optional build macro XADC_SCAN_AVG_EN: publish the mean of every four captures per channel.
module xadc_scan_pwm #(
    parameter int unsigned         NUM_CH  = 4,
    parameter int unsigned         DATA_W  = 8,
    parameter logic [7*NUM_CH-1:0] CH_ADDR = (7*NUM_CH)'({7'h16, 7'h1F, 7'h17, 7'h1E}),
    parameter int unsigned         TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    xadc_scan_pwm_if.master        drp,
    output logic [NUM_CH-1:0]      pwm_out,
    output logic                   sample_valid,
    output logic [2:0]             sample_ch,
    output logic [DATA_W-1:0]      sample_data,
    output logic                   timeout_err
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned TMO_W = 16;
    localparam int unsigned ACC_W = DATA_W + 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                launch_c;
    logic                capture_c;
    logic                expire_c;
    logic                publish_c;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt_c;
    logic [TMO_W-1:0]    wait_cnt;
    logic [6:0]          addr_c;
    logic [DATA_W-1:0]   capture_val_c;
    logic [DATA_W-1:0]   publish_val_c;
    logic [DATA_W-1:0]   data_q   [NUM_CH];
    logic [DATA_W-1:0]   duty_q   [NUM_CH];
    logic [DATA_W-1:0]   duty_nxt_c [NUM_CH];
    logic [DATA_W-1:0]   pwm_cnt;
    logic                unused_do;

    assign capture_val_c = drp.do_in[15 -: DATA_W];
    assign unused_do     = ^drp.do_in[15-DATA_W:0];
    assign idx_nxt_c     = (idx == IDX_W'(NUM_CH - 1)) ? '0 : idx + IDX_W'(1);

    // DRP address of the current channel
    always_comb begin
        addr_c = 7'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                addr_c = CH_ADDR[7*i +: 7];
            end
        end
    end

    // Scan FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Scan FSM next state: launch on eoc, finish on drdy (which beats a same-cycle timeout)
    always_comb begin
        state_nxt = state;
        launch_c  = 1'b0;
        capture_c = 1'b0;
        expire_c  = 1'b0;
        case (state)
            IDLE: begin
                if (drp.eoc_in) begin
                    launch_c  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (drp.drdy_in) begin
                    capture_c = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
                    expire_c  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // WAIT-cycle counter; the den_out cycle counts as the first WAIT cycle
    always_ff @(posedge clk) begin
        if (rst || launch_c) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + TMO_W'(1);
        end
    end

    // Channel index advances on every finished read, captured or abandoned
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (capture_c || expire_c) begin
            idx <= idx_nxt_c;
        end
    end

    // DRP request outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            drp.den_out   <= 1'b0;
            drp.dwe_out   <= 1'b0;
            drp.daddr_out <= 7'h00;
        end else begin
            drp.den_out   <= launch_c;
            drp.dwe_out   <= 1'b0;
            drp.daddr_out <= addr_c;
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (expire_c) begin
            timeout_err <= 1'b1;
        end
    end

`ifdef XADC_SCAN_AVG_EN
    logic [ACC_W-1:0] acc_q     [NUM_CH];
    logic [1:0]       acc_cnt_q [NUM_CH];
    logic [ACC_W-1:0] sel_acc_c;
    logic [1:0]       sel_cnt_c;
    logic [ACC_W-1:0] sum_c;

    // Accumulator state of the channel being read
    always_comb begin
        sel_acc_c = '0;
        sel_cnt_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_acc_c = acc_q[i];
                sel_cnt_c = acc_cnt_q[i];
            end
        end
    end

    assign sum_c         = sel_acc_c + ACC_W'(capture_val_c);
    assign publish_c     = capture_c && (sel_cnt_c == 2'd3);
    assign publish_val_c = sum_c[ACC_W-1:2];

    // Four-sample accumulators; cleared once the fourth sample is published
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                acc_q[i]     <= '0;
                acc_cnt_q[i] <= '0;
            end else if (capture_c && idx == IDX_W'(i)) begin
                if (acc_cnt_q[i] == 2'd3) begin
                    acc_q[i]     <= '0;
                    acc_cnt_q[i] <= '0;
                end else begin
                    acc_q[i]     <= sum_c;
                    acc_cnt_q[i] <= acc_cnt_q[i] + 2'd1;
                end
            end
        end
    end
`else
    assign publish_c     = capture_c;
    assign publish_val_c = capture_val_c;
`endif

    // Per-channel data registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                data_q[i] <= '0;
            end else if (publish_c && idx == IDX_W'(i)) begin
                data_q[i] <= publish_val_c;
            end
        end
    end

    // Stored-sample report, one cycle after the capture
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
        end else begin
            sample_valid <= publish_c;
            if (publish_c) begin
                sample_ch   <= idx;
                sample_data <= publish_val_c;
            end
        end
    end

    // Duty values take effect only at the start of a PWM period
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            duty_nxt_c[i] = (pwm_cnt == '0) ? data_q[i] : duty_q[i];
        end
    end

    // Free-running PWM counter, duty registers and comparators
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            pwm_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + DATA_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i]  <= duty_nxt_c[i];
                pwm_out[i] <= (pwm_cnt < duty_nxt_c[i]);
            end
        end
    end

endmodule

// File: doc/xadc_scan_pwm.md
XADC_SCAN_PWM -- requirements
Module: xadc_scan_pwm

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, number of scanned channels (legal 1..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, stored sample and PWM width (legal 4..12).
REQ-003 The block SHALL have parameter CH_ADDR, default {7'h16,7'h1F,7'h17,7'h1E}, packed DRP address per channel, channel 0 in bits [6:0].
REQ-004 The block SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abandoning a read (legal 2..65535).
REQ-005 The block SHALL have port clk, input, 1, the single clock; DRP and PWM logic both run on it.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port eoc_in, input, 1, XADC end-of-conversion pulse.
REQ-008 The block SHALL have port drdy_in, input, 1, DRP data-ready.
REQ-009 The block SHALL have port do_in, input, 16, DRP read data.
REQ-010 The block SHALL have port den_out, output, 1, DRP enable, one-cycle pulse.
REQ-011 The block SHALL have port dwe_out, output, 1, DRP write enable, tied 0.
REQ-012 The block SHALL have port daddr_out, output, 7, DRP address.
REQ-013 The block SHALL have port pwm_out, output, NUM_CH, per-channel PWM brightness.
REQ-014 The block SHALL have port sample_valid, output, 1, one-cycle pulse marking a stored sample.
REQ-015 The block SHALL have port sample_ch, output, 3, channel index of the stored sample.
REQ-016 The block SHALL have port sample_data, output, DATA_W, value of the stored sample.
REQ-017 The block SHALL have port timeout_err, output, 1, sticky DRP-timeout flag.

Function
REQ-018 The FSM SHALL have states IDLE and WAIT; in IDLE, eoc_in=1 SHALL pulse den_out for one cycle with daddr_out = CH_ADDR slice of the current index idx, then enter WAIT.
REQ-019 daddr_out SHALL always equal the CH_ADDR slice of idx, registered.
REQ-020 In WAIT, drdy_in=1 SHALL capture do_in[15:16-DATA_W] into the register of channel idx, advance idx, and return to IDLE.
REQ-021 sample_valid SHALL pulse in the cycle after drdy_in, with sample_ch=idx and sample_data=the captured value (latency 1 cycle).
REQ-022 idx SHALL wrap from NUM_CH-1 to 0; with NUM_CH=1, idx SHALL stay 0.
REQ-023 eoc_in during WAIT and drdy_in during IDLE SHALL be ignored.
REQ-024 If WAIT lasts TIMEOUT cycles without drdy_in, the FSM SHALL set timeout_err, advance idx without updating data, suppress sample_valid, and return to IDLE.
REQ-025 drdy_in arriving in the same cycle as the timeout SHALL win: the sample SHALL be stored and timeout_err SHALL NOT be set.
REQ-026 A free-running DATA_W-bit PWM counter SHALL wrap from 2^DATA_W-1 to 0.
REQ-027 Per-channel duty registers SHALL load from the channel data registers only in cycles where the counter is 0.
REQ-028 pwm_out[i] SHALL be 1 when the counter is less than duty[i]; duty 0 SHALL give constant 0, and duty 2^DATA_W-1 SHALL give 1 for all but one cycle per period.
REQ-029 timeout_err SHALL clear only on rst.

Reset
REQ-030 rst SHALL force FSM=IDLE, idx=0, all data and duty registers=0, PWM counter=0, and clear timeout_err.
REQ-031 rst SHALL drive den_out, sample_valid, sample_ch, sample_data, pwm_out, and daddr_out to 0 (CH_ADDR of index 0 on the cycle after).
REQ-032 rst asserted in WAIT SHALL abandon the read, and a later drdy_in SHALL be ignored.

Configuration
REQ-033 When macro XADC_SCAN_AVG_EN is defined, each channel SHALL accumulate 4 captured samples in a (DATA_W+2)-bit accumulator with a 2-bit count.
REQ-034 With XADC_SCAN_AVG_EN defined, the data register and sample_valid SHALL update only on the 4th sample, with value sum>>2, after which the accumulator resets; timeouts SHALL not advance the count.
REQ-035 When XADC_SCAN_AVG_EN is undefined, every capture SHALL update the data register and pulse sample_valid, and no accumulator SHALL exist.

Verification
REQ-036 Four eoc/drdy rounds with do_in=16'hAB00,16'h1200,16'hFF00,16'h0000 (DATA_W=8) -> daddr_out sequence 1E,17,1F,16; sample_data AB,12,FF,00 on sample_ch 0..3; idx back to 0.
REQ-037 Data ch0=8'h40 -> after the next counter wrap, pwm_out[0] is high for exactly 64 of 256 cycles; ch3=0 -> pwm_out[3] never high.
REQ-038 eoc_in with no drdy_in for 255 cycles -> timeout_err=1, no sample_valid, next den_out uses the channel-1 address; drdy_in exactly at cycle 255 -> stored, no error.
REQ-039 rst pulsed 3 cycles after den_out, then drdy_in -> no sample_valid, all outputs 0, idx=0.
REQ-040 With XADC_SCAN_AVG_EN defined and NUM_CH=1, samples 10,20,30,41 (DATA_W=8) -> a single sample_valid with data 25, on the 4th drdy_in only.
